i2c_codec_responder: RTL and testbench
======================================

# i2c_codec_responder

I2C write-only responder that models the audio codec's control port. It receives the 3-byte register write frames issued by the codec init sequencer: device address, then a 7-bit register address plus 9-bit data. It acknowledges each byte and commits the data into a 16-entry × 9-bit register file. It is used as the on-chip codec stand-in for simulation and loopback builds, and as the bus monitor for the init path.

## Interface
- DEV_ADDR, 7'h1A: 7-bit device address (the frame's first byte is 0x34 for a write).
- i_clk  in  1: system clock; must be at least 4× the rate at which SCL changes level.
- i_rst_n  in  1: reset, asynchronous, active-low.
- i_scl  in  1: SCL as seen on the bus; asynchronous to i_clk.
- i_sda  in  1: SDA as seen on the bus (resolved wire value); asynchronous.
- o_sda_low  out  1: 1 = pull SDA low (open-drain); 0 = release.
- o_wr_valid  out  1: one-cycle pulse when a complete frame is committed.
- o_wr_addr  out  7: register address of the committed frame; held until the next commit.
- o_wr_data  out  9: data of the committed frame; held until the next commit.
- i_rd_addr  in  4: register file read index.
- o_rd_data  out  9: combinational read of register i_rd_addr.
- o_busy  out  1: 1 from a detected START until STOP or a return to IDLE.
- o_frame_err  out  1: one-cycle pulse when a STOP or repeated START aborts an addressed frame before the second data byte is acknowledged.

## Operation
- Input conditioning:
  - i_scl and i_sda each pass through a 2-FF synchronizer, reset to 1.
  - A third flop per line holds the previous value for edge detection.
- Bus events, all on synchronized values:
  - START: SDA 1→0 while SCL = 1.
  - STOP: SDA 0→1 while SCL = 1.
  - SCL rise: data sample point.
  - SCL fall: point where the responder may change SDA.
- Data order: bits are sampled on SCL rise, MSB first, into an 8-bit shift register; a 3-bit counter counts bits.
- FSM states:
  - IDLE → ADDR on START.
  - ADDR: after 8 bits, if byte[7:1] == DEV_ADDR and byte[0] == 0, go to ACK_A. Otherwise go to IGNORE (never drives SDA).
  - ACK_A: o_sda_low = 1 from the SCL fall that ends bit 8 until the next SCL fall. Then go to BYTE1.
  - BYTE1: latch the register address (byte[7:1]) and data bit 8 (byte[0]). Then go to ACK_1, which behaves the same as ACK_A.
  - BYTE2: latch data[7:0]. Then go to ACK_2.
  - ACK_2: commit on entry (at the SCL fall that ends bit 8). Drive the ACK, then go to WAIT_STOP.
  - WAIT_STOP: further bytes are not acknowledged (SDA stays released). Exits only on STOP or START.
  - IGNORE: exits only on STOP or START.
- Commit:
  - o_wr_valid pulses for 1 cycle; o_wr_addr and o_wr_data update in the same cycle.
  - If addr < 16, register addr = data.
  - If addr == 0x0F (RESET), registers 0..15 all clear to 0 instead.
  - If addr ≥ 16, the frame is still acknowledged and o_wr_valid still pulses, but the register file is unchanged.
- STOP in any state: go to IDLE and release SDA.
- START in any state (repeated start): go to ADDR, clear the bit counter, release SDA.
- o_frame_err pulses when either event occurs in ACK_A, BYTE1, ACK_1 or BYTE2, and also in ACK_2 before commit (not reachable, since commit happens on entry).
- STOP or START in ADDR, IGNORE, WAIT_STOP or IDLE does not raise an error.

## Timing
- Reset values:
  - o_sda_low = 0, o_wr_valid = 0, o_wr_addr = 0, o_wr_data = 0, o_busy = 0, o_frame_err = 0.
  - All registers = 0; FSM in IDLE; synchronizers = 1.
- Event latency: a bus edge is recognised 3 i_clk cycles after the raw pin change (2 sync + 1 edge register).
- ACK drive: o_sda_low rises in the cycle after the SCL fall is detected, and falls in the cycle after the next SCL fall is detected.
- Commit: o_wr_valid is asserted in the same cycle o_sda_low rises for ACK_2. The register file shows the new value on o_rd_data from the next cycle.
- o_busy: set in the cycle START is detected; cleared in the cycle STOP is detected.
- Simultaneous SCL and SDA change in one sample: treated as a data edge, not START/STOP. Masters must not do this.
- Asynchronous reset mid-frame: all outputs go to reset values immediately, SDA is released, and no commit occurs.
- Bit counter wraps 7→0 at the end of every byte.

## Test plan
- Full init sequence: 10 frames (0x34, {reg, d8}, d[7:0]) for regs 0x00–0x09 with data 0x097, 0x097, 0x079, 0x079, 0x015, 0x000, 0x000, 0x042, 0x019, 0x001.
  - Required: 30 ACKs, 10 o_wr_valid pulses, register reads match the data, o_frame_err never asserted.
- Wrong device (first byte 0x36) or read bit (0x35):
  - Required: o_sda_low stays 0 for the whole frame, no o_wr_valid, registers unchanged.
- STOP after the register byte is acknowledged:
  - Required: o_frame_err pulses once, no o_wr_valid, o_busy drops, and the next valid frame commits normally.
- Repeated START mid-BYTE2 followed by a full frame writing reg 0x04 = 0x1FF:
  - Required: one o_frame_err, then one commit with register 4 = 0x1FF.
- Write 0x0F = 0x000 after the init sequence:
  - Required: o_wr_valid with o_wr_addr = 0x0F, and all registers read 0 on the next cycle.
  - Also: a write to addr 0x20 is acknowledged with o_wr_valid, but no register changes.
- Assert i_rst_n = 0 while o_sda_low = 1 during ACK_1:
  - Required: o_sda_low = 0 immediately, no commit, and o_busy = 0.

Source files
------------

// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - write-only I2C codec control-port responder with 16x9 register file
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_low,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic       o_frame_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_WAIT_STOP, S_IGNORE
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] scl_sh, sda_sh;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [6:0] addr_lat;
    logic       d8_lat;
    logic [8:0] regs [16];

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, bus_start, bus_stop;
    logic sda_low_nxt, commit, latch1, err, in_frame, shifting;

    // [1] is the synchronized value, [2] the previous one for edge detection
    assign scl_s = scl_sh[1];
    assign scl_d = scl_sh[2];
    assign sda_s = sda_sh[1];
    assign sda_d = sda_sh[2];

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign bus_start = scl_s & scl_d & sda_d & ~sda_s;
    assign bus_stop  = scl_s & scl_d & ~sda_d & sda_s;

    assign in_frame = (state == S_ACK_A) || (state == S_BYTE1) ||
                      (state == S_ACK_1) || (state == S_BYTE2);
    assign shifting = (state == S_ADDR) || (state == S_BYTE1) || (state == S_BYTE2);

    assign o_rd_data = regs[i_rd_addr];

    always_comb begin
        state_nxt   = state;
        sda_low_nxt = o_sda_low;
        commit      = 1'b0;
        latch1      = 1'b0;
        err         = 1'b0;
        if (bus_stop) begin
            state_nxt   = S_IDLE;
            sda_low_nxt = 1'b0;
            err         = in_frame;
        end else if (bus_start) begin
            state_nxt   = S_ADDR;
            sda_low_nxt = 1'b0;
            err         = in_frame;
        end else if (scl_fall) begin
            case (state)
                S_ADDR: if (byte_done) begin
                    if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                        state_nxt   = S_ACK_A;
                        sda_low_nxt = 1'b1;
                    end else begin
                        state_nxt = S_IGNORE;
                    end
                end
                S_ACK_A: begin
                    state_nxt   = S_BYTE1;
                    sda_low_nxt = 1'b0;
                end
                S_BYTE1: if (byte_done) begin
                    latch1      = 1'b1;
                    state_nxt   = S_ACK_1;
                    sda_low_nxt = 1'b1;
                end
                S_ACK_1: begin
                    state_nxt   = S_BYTE2;
                    sda_low_nxt = 1'b0;
                end
                S_BYTE2: if (byte_done) begin
                    commit      = 1'b1;
                    state_nxt   = S_ACK_2;
                    sda_low_nxt = 1'b1;
                end
                S_ACK_2: begin
                    state_nxt   = S_WAIT_STOP;
                    sda_low_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sh      <= 3'b111;
            sda_sh      <= 3'b111;
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            addr_lat    <= '0;
            d8_lat      <= 1'b0;
            o_sda_low   <= 1'b0;
            o_wr_valid  <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            scl_sh      <= {scl_sh[1:0], i_scl};
            sda_sh      <= {sda_sh[1:0], i_sda};
            o_sda_low   <= sda_low_nxt;
            o_wr_valid  <= commit;
            o_frame_err <= err;
            if (bus_stop)       o_busy <= 1'b0;
            else if (bus_start) o_busy <= 1'b1;

            if (bus_start || bus_stop) begin
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else if (scl_rise && shifting) begin
                shreg     <= {shreg[6:0], sda_s};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end else if (scl_fall) begin
                byte_done <= 1'b0;
            end

            if (latch1) begin
                addr_lat <= shreg[7:1];
                d8_lat   <= shreg[0];
            end

            if (commit) begin
                o_wr_addr <= addr_lat;
                o_wr_data <= {d8_lat, shreg};
                // 0x0F is the codec's soft-reset register: clears the whole file
                if (addr_lat == 7'h0F) begin
                    for (int i = 0; i < 16; i++) regs[i] <= '0;
                end else if (addr_lat < 7'd16) begin
                    regs[addr_lat[3:0]] <= {d8_lat, shreg};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - directed bench for i2c_codec_responder
module tb_i2c_codec_responder;

    localparam time Q = 100ns;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       o_sda_low, o_wr_valid, o_busy, o_frame_err;
    logic [6:0] o_wr_addr;
    logic [8:0] o_wr_data;
    logic [3:0] i_rd_addr = '0;
    logic [8:0] o_rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int err_cnt = 0;
    logic sda_seen = 1'b0;
    logic [6:0] last_addr = '0;
    logic [8:0] last_data = '0;

    assign sda_bus = sda_m & ~o_sda_low;

    always #5ns i_clk = ~i_clk;

    i2c_codec_responder dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_scl       (scl_m),
        .i_sda       (sda_bus),
        .o_sda_low   (o_sda_low),
        .o_wr_valid  (o_wr_valid),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err)
    );

    always @(negedge i_clk) begin
        if (o_wr_valid) begin
            wr_cnt++;
            last_addr = o_wr_addr;
            last_data = o_wr_data;
        end
        if (o_frame_err) err_cnt++;
        if (o_sda_low) sda_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output int ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = (sda_bus == 1'b0) ? 1 : 0;
        #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_frame(input logic [7:0] b0, input logic [6:0] ra, input logic [8:0] d,
                               output int acks);
        int a;
        acks = 0;
        bus_start();
        send_byte(b0, a);            acks += a;
        send_byte({ra, d[8]}, a);    acks += a;
        send_byte(d[7:0], a);        acks += a;
        bus_stop();
        #Q;
    endtask

    logic [8:0] init_data [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h015,
                                   9'h000, 9'h000, 9'h042, 9'h019, 9'h001};

    initial begin
        int acks, tot_acks, a, w0;
        logic [8:0] exp_reg [16];

        #(2*Q);
        check("rst_sda_low", o_sda_low, 0);
        check("rst_wr_valid", o_wr_valid, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_reg0", o_rd_data, 0);
        i_rst_n = 1'b1;
        #Q;

        for (int i = 0; i < 16; i++) exp_reg[i] = '0;
        tot_acks = 0;
        for (int i = 0; i < 10; i++) begin
            write_frame(8'h34, 7'(i), init_data[i], acks);
            tot_acks += acks;
            exp_reg[i] = init_data[i];
        end
        check("init_acks", tot_acks, 30);
        check("init_wr_cnt", wr_cnt, 10);
        check("init_frame_err", err_cnt, 0);
        check("init_last_addr", last_addr, 7'h09);
        check("init_last_data", last_data, 9'h001);
        check("init_busy_idle", o_busy, 0);
        for (int i = 0; i < 16; i++) begin
            i_rd_addr = 4'(i); #1;
            check($sformatf("init_reg%0d", i), o_rd_data, exp_reg[i]);
        end

        sda_seen = 1'b0;
        write_frame(8'h36, 7'h02, 9'h1AA, acks);
        write_frame(8'h35, 7'h03, 9'h155, acks);
        check("wrongdev_sda_seen", sda_seen, 0);
        check("wrongdev_wr_cnt", wr_cnt, 10);
        i_rd_addr = 4'd2; #1;
        check("wrongdev_reg2", o_rd_data, 9'h079);
        i_rd_addr = 4'd3; #1;
        check("wrongdev_reg3", o_rd_data, 9'h079);

        bus_start();
        send_byte(8'h34, a);
        send_byte({7'h03, 1'b0}, a);
        check("abort_reg_ack", a, 1);
        bus_stop();
        #Q;
        check("abort_frame_err", err_cnt, 1);
        check("abort_wr_cnt", wr_cnt, 10);
        check("abort_busy", o_busy, 0);
        write_frame(8'h34, 7'h05, 9'h0AB, acks);
        check("after_abort_acks", acks, 3);
        check("after_abort_wr_cnt", wr_cnt, 11);
        i_rd_addr = 4'd5; #1;
        check("after_abort_reg5", o_rd_data, 9'h0AB);
        i_rd_addr = 4'd3; #1;
        check("after_abort_reg3", o_rd_data, 9'h079);

        bus_start();
        send_byte(8'h34, a);
        send_byte({7'h06, 1'b1}, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_start();
        send_byte(8'h34, a);
        send_byte({7'h04, 1'b1}, a);
        send_byte(8'hFF, a);
        bus_stop();
        #Q;
        check("rstart_frame_err", err_cnt, 2);
        check("rstart_wr_cnt", wr_cnt, 12);
        check("rstart_last_addr", last_addr, 7'h04);
        i_rd_addr = 4'd4; #1;
        check("rstart_reg4", o_rd_data, 9'h1FF);
        i_rd_addr = 4'd6; #1;
        check("rstart_reg6", o_rd_data, 9'h000);

        write_frame(8'h34, 7'h20, 9'h155, acks);
        check("hi_addr_acks", acks, 3);
        check("hi_addr_wr_cnt", wr_cnt, 13);
        check("hi_addr_last_addr", last_addr, 7'h20);
        check("hi_addr_last_data", last_data, 9'h155);
        i_rd_addr = 4'd0; #1;
        check("hi_addr_reg0", o_rd_data, 9'h097);
        i_rd_addr = 4'd4; #1;
        check("hi_addr_reg4", o_rd_data, 9'h1FF);

        write_frame(8'h34, 7'h0F, 9'h000, acks);
        check("softrst_wr_cnt", wr_cnt, 14);
        check("softrst_last_addr", last_addr, 7'h0F);
        for (int i = 0; i < 16; i++) begin
            i_rd_addr = 4'(i); #1;
            check($sformatf("softrst_reg%0d", i), o_rd_data, 0);
        end
        check("total_frame_err", err_cnt, 2);

        write_frame(8'h34, 7'h01, 9'h123, acks);
        w0 = wr_cnt;
        bus_start();
        send_byte(8'h34, a);
        for (int i = 7; i >= 0; i--) send_bit(i == 1);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #(Q/2);
        check("arst_pre_sda_low", o_sda_low, 1);
        check("arst_pre_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        check("arst_sda_low", o_sda_low, 0);
        check("arst_busy", o_busy, 0);
        check("arst_wr_valid", o_wr_valid, 0);
        i_rd_addr = 4'd1; #1;
        check("arst_reg1", o_rd_data, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        #Q;
        i_rst_n = 1'b1;
        #(2*Q);
        check("arst_no_commit", wr_cnt, w0);
        check("arst_sda_after", o_sda_low, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
